// File: rtl/qam_symbol_mapper_if.sv
// Symbol stream toward the OTFS grid writer: valid/ready handshake carrying
// one signed I/Q pair plus an end-of-frame tag.
interface qam_symbol_mapper_if #(
    parameter int unsigned IQ_W = 16
);
    logic                   sym_valid;
    logic                   sym_ready;
    logic signed [IQ_W-1:0] sym_i;
    logic signed [IQ_W-1:0] sym_q;
    logic                   sym_last;

    modport master (
        output sym_valid,
        output sym_i,
        output sym_q,
        output sym_last,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_i,
        input  sym_q,
        input  sym_last,
        output sym_ready
    );
endinterface

// File: rtl/qam_symbol_mapper.sv
// Packs a serial bit stream into BPSK/4QAM/16QAM Gray-coded I/Q symbols,
// buffers them in a small FIFO and tags the last symbol of each OTFS frame.
module qam_symbol_mapper #(
    parameter int unsigned IQ_W       = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned AMP_BPSK   = 32767,
    parameter int unsigned AMP_QPSK   = 23170,
    parameter int unsigned AMP_16QAM  = 10362
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          modulation_order,
    input  logic                bit_valid,
    input  logic                serial_bit,
    qam_symbol_mapper_if.master sym,
    output logic                overflow,
    output logic                mod_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FRAME_LEN + 1);

    localparam logic [2:0] ORD_BPSK  = 3'b000;
    localparam logic [2:0] ORD_QAM4  = 3'b001;
    localparam logic [2:0] ORD_QAM16 = 3'b010;

    localparam logic signed [IQ_W-1:0] BPSK_P = IQ_W'(AMP_BPSK);
    localparam logic signed [IQ_W-1:0] QPSK_P = IQ_W'(AMP_QPSK);
    localparam logic signed [IQ_W-1:0] Q16_1  = IQ_W'(AMP_16QAM);
    localparam logic signed [IQ_W-1:0] Q16_3  = IQ_W'(3 * AMP_16QAM);

    typedef struct packed {
        logic signed [IQ_W-1:0] i;
        logic signed [IQ_W-1:0] q;
        logic                   last;
    } sym_t;

    logic [2:0]             order_q;
    logic [1:0]             bit_cnt;
    logic [3:0]             acc;
    logic [FW-1:0]          frame_cnt;
    sym_t                   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    sym_t                   head_q;
    logic                   valid_q;

    logic [1:0]             k_last;
    logic [3:0]             bits_c;
    logic signed [IQ_W-1:0] mag_i;
    logic signed [IQ_W-1:0] mag_q;
    sym_t                   map_c;
    logic                   sym_done;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [AW-1:0]          rd_next;
    logic [CW-1:0]          cnt_next;
    sym_t                   head_next;

    // Symbol mapping from the stored bits plus the bit arriving this cycle
    always_comb begin
        k_last = 2'd0;
        case (order_q)
            ORD_QAM4:  k_last = 2'd1;
            ORD_QAM16: k_last = 2'd3;
            default:   k_last = 2'd0;
        endcase

        bits_c          = acc;
        bits_c[bit_cnt] = serial_bit;

        // 16QAM Gray levels: first bit of a pair is the sign, second picks 1 vs 3
        mag_i = bits_c[1] ? Q16_1 : Q16_3;
        mag_q = bits_c[3] ? Q16_1 : Q16_3;

        map_c      = '0;
        map_c.last = (frame_cnt == FW'(FRAME_LEN - 1));
        case (order_q)
            ORD_BPSK: begin
                map_c.i = bits_c[0] ? -BPSK_P : BPSK_P;
            end
            ORD_QAM4: begin
                map_c.i = bits_c[0] ? -QPSK_P : QPSK_P;
                map_c.q = bits_c[1] ? -QPSK_P : QPSK_P;
            end
            ORD_QAM16: begin
                map_c.i = bits_c[0] ? -mag_i : mag_i;
                map_c.q = bits_c[2] ? -mag_q : mag_q;
            end
            default: begin
                map_c.i = '0;
                map_c.q = '0;
            end
        endcase
    end

    assign sym_done = bit_valid & ~start & ~mod_err & (bit_cnt == k_last);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = valid_q & sym.sym_ready;
    assign push     = sym_done & (~full | pop);
    assign drop     = sym_done & full & ~pop;
    assign rd_next  = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign cnt_next = count + CW'(push) - CW'(pop);

    // Next head entry; a push lands directly at the head when it becomes the only entry
    always_comb begin
        head_next = mem[rd_next];
        if (push && (wr_ptr == rd_next)) begin
            head_next = map_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= map_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q   <= ORD_QAM4;
            mod_err   <= 1'b0;
            overflow  <= 1'b0;
            bit_cnt   <= '0;
            acc       <= '0;
            frame_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
        end else if (start) begin
            order_q   <= modulation_order;
            mod_err   <= (modulation_order > ORD_QAM16);
            overflow  <= 1'b0;
            bit_cnt   <= '0;
            frame_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (bit_valid && !mod_err) begin
                acc[bit_cnt] <= serial_bit;
                bit_cnt      <= (bit_cnt == k_last) ? 2'd0 : bit_cnt + 2'd1;
            end
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                frame_cnt <= map_c.last ? '0 : frame_cnt + FW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            rd_ptr  <= rd_next;
            count   <= cnt_next;
            valid_q <= (cnt_next != '0);
            if (cnt_next != '0) begin
                head_q <= head_next;
            end
        end
    end

    assign sym.sym_valid = valid_q;
    assign sym.sym_i     = head_q.i;
    assign sym.sym_q     = head_q.q;
    assign sym.sym_last  = head_q.last;

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Self-checking bench for qam_symbol_mapper: directed cases plus randomized
// symbols against a table-driven constellation/frame model.
module tb_qam_symbol_mapper;

    localparam int IQ_W       = 16;
    localparam int DEPTH      = 4;
    localparam int FRAME_LEN  = 4;
    localparam int A_BPSK     = 32767;
    localparam int A_QPSK     = 23170;
    localparam int A_16       = 10362;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] modulation_order;
    logic       bit_valid;
    logic       serial_bit;
    logic       overflow;
    logic       mod_err;

    qam_symbol_mapper_if #(.IQ_W(IQ_W)) bus ();

    qam_symbol_mapper #(
        .IQ_W      (IQ_W),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .modulation_order(modulation_order),
        .bit_valid       (bit_valid),
        .serial_bit      (serial_bit),
        .sym             (bus),
        .overflow        (overflow),
        .mod_err         (mod_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   i;
        int   q;
        logic last;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int mframe = 0;

    // Constellation by lookup: order 0/1/2 -> 1/2/4 bits, b[0] received first
    function automatic exp_t sym_model(input int order, input logic [3:0] b);
        int   lv [4] = '{3, 1, -3, -1};
        exp_t e;
        e.last = 1'b0;
        case (order)
            0: begin e.i = b[0] ? -A_BPSK : A_BPSK; e.q = 0; end
            1: begin e.i = b[0] ? -A_QPSK : A_QPSK; e.q = b[1] ? -A_QPSK : A_QPSK; end
            default: begin
                e.i = lv[{b[0], b[1]}] * A_16;
                e.q = lv[{b[2], b[3]}] * A_16;
            end
        endcase
        return e;
    endfunction

    // Frame position of one accepted symbol
    function automatic logic take_last();
        mframe = mframe + 1;
        if (mframe == FRAME_LEN) begin
            mframe = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int bits_per(input int order);
        return (order == 0) ? 1 : (order == 1) ? 2 : 4;
    endfunction

    task automatic do_start(input logic [2:0] o);
        start = 1'b1;
        modulation_order = o;
        @(posedge clk); #1;
        start = 1'b0;
        mframe = 0;
    endtask

    task automatic drive_bit(input logic b);
        bit_valid  = 1'b1;
        serial_bit = b;
        @(posedge clk); #1;
        bit_valid  = 1'b0;
    endtask

    task automatic send_sym(input int k, input logic [3:0] b);
        for (int j = 0; j < k; j++) drive_bit(b[j]);
    endtask

    task automatic test_reset();
        checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.sym_valid); end
        checks++; if (bus.sym_i !== '0) begin errors++; $display("FAIL reset_i got %0d want 0", bus.sym_i); end
        checks++; if (bus.sym_q !== '0) begin errors++; $display("FAIL reset_q got %0d want 0", bus.sym_q); end
        checks++; if (bus.sym_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", bus.sym_last); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        checks++; if (mod_err !== 1'b0) begin errors++; $display("FAIL reset_moderr got %0b want 0", mod_err); end
    endtask

    task automatic test_qam4();
        logic [3:0] pats [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
        int         ei   [4] = '{23170, -23170, 23170, -23170};
        int         eq   [4] = '{23170, 23170, -23170, -23170};
        bus.sym_ready = 1'b1;
        do_start(3'b001);
        for (int n = 0; n < 4; n++) begin
            drive_bit(pats[n][0]);
            checks++;
            if (bus.sym_valid !== 1'b0) begin
                errors++; $display("FAIL qam4_midsym%0d valid got %0b want 0", n, bus.sym_valid);
            end
            drive_bit(pats[n][1]);
            checks++;
            if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== ei[n] || int'(bus.sym_q) !== eq[n]
                || bus.sym_last !== (n == 3)) begin
                errors++;
                $display("FAIL qam4_sym%0d got v=%0b i=%0d q=%0d l=%0b want v=1 i=%0d q=%0d l=%0b",
                         n, bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, ei[n], eq[n], n == 3);
            end
        end
    endtask

    task automatic test_bpsk();
        logic bits [2] = '{1'b1, 1'b0};
        int   ei   [2] = '{-32767, 32767};
        bus.sym_ready = 1'b1;
        do_start(3'b000);
        for (int n = 0; n < 2; n++) begin
            drive_bit(bits[n]);
            checks++;
            if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== ei[n] || int'(bus.sym_q) !== 0) begin
                errors++;
                $display("FAIL bpsk_sym%0d got v=%0b i=%0d q=%0d want v=1 i=%0d q=0",
                         n, bus.sym_valid, bus.sym_i, bus.sym_q, ei[n]);
            end
        end
    endtask

    task automatic test_16qam();
        logic [3:0] pats [2] = '{4'b0100, 4'b1110};
        int         ei   [2] = '{31086, 10362};
        int         eq   [2] = '{-31086, -10362};
        bus.sym_ready = 1'b1;
        do_start(3'b010);
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 3; j++) drive_bit(pats[n][j]);
            checks++;
            if (bus.sym_valid !== 1'b0) begin
                errors++; $display("FAIL qam16_midsym%0d valid got %0b want 0", n, bus.sym_valid);
            end
            drive_bit(pats[n][3]);
            checks++;
            if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== ei[n] || int'(bus.sym_q) !== eq[n]) begin
                errors++;
                $display("FAIL qam16_sym%0d got v=%0b i=%0d q=%0d want v=1 i=%0d q=%0d",
                         n, bus.sym_valid, bus.sym_i, bus.sym_q, ei[n], eq[n]);
            end
        end
    endtask

    task automatic test_random();
        exp_t       e;
        logic [3:0] b;
        int         order;
        bus.sym_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            order = int'($urandom_range(0, 2));
            do_start(3'(order));
            for (int n = 0; n < 8; n++) begin
                b = 4'($urandom);
                e = sym_model(order, b);
                e.last = take_last();
                send_sym(bits_per(order), b);
                checks++;
                if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== e.i || int'(bus.sym_q) !== e.q
                    || bus.sym_last !== e.last) begin
                    errors++;
                    $display("FAIL rand_o%0d_sym%0d bits=%b got v=%0b i=%0d q=%0d l=%0b want v=1 i=%0d q=%0d l=%0b",
                             order, n, b, bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, e.i, e.q, e.last);
                end
            end
        end
    endtask

    task automatic test_overflow();
        exp_t       expq [$];
        exp_t       e;
        logic [3:0] b;
        bus.sym_ready = 1'b0;
        do_start(3'b001);
        for (int n = 0; n < 5; n++) begin
            b = 4'($urandom);
            if (n < DEPTH) begin
                e = sym_model(1, b);
                e.last = take_last();
                expq.push_back(e);
            end
            send_sym(2, b);
            checks++;
            if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== expq[0].i || int'(bus.sym_q) !== expq[0].q) begin
                errors++;
                $display("FAIL ovf_hold%0d got v=%0b i=%0d q=%0d want v=1 i=%0d q=%0d",
                         n, bus.sym_valid, bus.sym_i, bus.sym_q, expq[0].i, expq[0].q);
            end
            checks++;
            if (overflow !== (n == 4)) begin
                errors++; $display("FAIL ovf_flag%0d got %0b want %0b", n, overflow, n == 4);
            end
        end
        bus.sym_ready = 1'b1;
        for (int n = 0; n < DEPTH; n++) begin
            checks++;
            if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== expq[n].i || int'(bus.sym_q) !== expq[n].q
                || bus.sym_last !== expq[n].last) begin
                errors++;
                $display("FAIL ovf_drain%0d got v=%0b i=%0d q=%0d l=%0b want v=1 i=%0d q=%0d l=%0b",
                         n, bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, expq[n].i, expq[n].q, expq[n].last);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.sym_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_empty valid got %0b want 0", bus.sym_valid);
        end
    endtask

    task automatic test_frame();
        exp_t       e;
        logic [3:0] b;
        bus.sym_ready = 1'b1;
        // Start and a bit in the same cycle: the bit must be dropped
        start = 1'b1; modulation_order = 3'b001; bit_valid = 1'b1; serial_bit = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b0; mframe = 0;
        for (int p = 0; p < 2; p++) begin
            for (int n = 0; n < 8; n++) begin
                if (p == 1 && n == 4) break;
                if (p == 1 && n == 0) begin
                    drive_bit(1'b1);
                    do_start(3'b001);
                end
                b = 4'($urandom);
                e = sym_model(1, b);
                e.last = take_last();
                send_sym(2, b);
                checks++;
                if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== e.i || int'(bus.sym_q) !== e.q
                    || bus.sym_last !== (n % 4 == 3)) begin
                    errors++;
                    $display("FAIL frame_p%0d_sym%0d got v=%0b i=%0d q=%0d l=%0b want v=1 i=%0d q=%0d l=%0b",
                             p, n, bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, e.i, e.q, n % 4 == 3);
                end
            end
        end
    endtask

    task automatic test_moderr();
        exp_t e;
        bus.sym_ready = 1'b1;
        do_start(3'b011);
        checks++;
        if (mod_err !== 1'b1) begin errors++; $display("FAIL moderr_set got %0b want 1", mod_err); end
        for (int n = 0; n < 8; n++) begin
            drive_bit(1'($urandom));
            checks++;
            if (bus.sym_valid !== 1'b0) begin
                errors++; $display("FAIL moderr_novalid%0d got %0b want 0", n, bus.sym_valid);
            end
        end
        do_start(3'b001);
        checks++;
        if (mod_err !== 1'b0) begin errors++; $display("FAIL moderr_clear got %0b want 0", mod_err); end
        e = sym_model(1, 4'b0010);
        send_sym(2, 4'b0010);
        checks++;
        if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== e.i || int'(bus.sym_q) !== e.q) begin
            errors++;
            $display("FAIL moderr_resume got v=%0b i=%0d q=%0d want v=1 i=%0d q=%0d",
                     bus.sym_valid, bus.sym_i, bus.sym_q, e.i, e.q);
        end
    endtask

    task automatic test_async_reset();
        exp_t       e;
        logic [3:0] b;
        bus.sym_ready = 1'b0;
        do_start(3'b010);
        for (int n = 0; n < 5; n++) send_sym(4, 4'($urandom));
        checks++;
        if (overflow !== 1'b1 || bus.sym_valid !== 1'b1) begin
            errors++; $display("FAIL arst_pre got ovf=%0b v=%0b want 1 1", overflow, bus.sym_valid);
        end
        drive_bit(1'b1);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, overflow, mod_err} !== '0) begin
            errors++;
            $display("FAIL arst_outputs got v=%0b i=%0d q=%0d l=%0b ovf=%0b me=%0b want all 0",
                     bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, overflow, mod_err);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset leaves order 4QAM latched, so no Start is needed
        bus.sym_ready = 1'b1;
        mframe = 0;
        b = 4'($urandom);
        e = sym_model(1, b);
        e.last = take_last();
        send_sym(2, b);
        checks++;
        if (bus.sym_valid !== 1'b1 || int'(bus.sym_i) !== e.i || int'(bus.sym_q) !== e.q
            || bus.sym_last !== e.last) begin
            errors++;
            $display("FAIL arst_default_order got v=%0b i=%0d q=%0d l=%0b want v=1 i=%0d q=%0d l=%0b",
                     bus.sym_valid, bus.sym_i, bus.sym_q, bus.sym_last, e.i, e.q, e.last);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        modulation_order = 3'b000;
        bit_valid        = 1'b0;
        serial_bit       = 1'b0;
        bus.sym_ready    = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_qam4();
        test_bpsk();
        test_16qam();
        test_random();
        test_overflow();
        test_frame();
        test_moderr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
